// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 key event receiver
package ps2_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    // Odd parity over a data byte plus its parity bit holds when the XOR is 1.
    function automatic logic ps2_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser plus consecutive-sample glitch filter
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    // Two-stage synchroniser; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

    // Output follows the synchronised line only after FILTER_LEN equal differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (sync_q == filt_q) begin
            cnt_q  <= '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_q <= sync_q;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// rtl/ps2_key_event_rx.sv - PS/2 frame receiver, prefix decoder and event FIFO
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic                        evt_break,
    output logic                        evt_ext,
    output logic [7:0]                  evt_code,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    logic clk_f;
    logic data_f;
    logic clk_prev_q;
    logic fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (ps2_clk),
        .line_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (ps2_data),
        .line_o (data_f)
    );

    // Previous filtered clock, used to form the falling-edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_f;
        end
    end

    assign fall = clk_prev_q & ~clk_f;

    ps2_rx_state_t state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          bad_par_q, bad_par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          byte_done_q, byte_done_d;
    logic [7:0]    byte_q, byte_d;
    logic          err_par_q, err_par_d;
    logic          err_frm_q, err_frm_d;
    logic          timeout;

    // Frame FSM and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            bad_par_q   <= 1'b0;
            wd_q        <= '0;
            byte_done_q <= 1'b0;
            byte_q      <= '0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            bad_par_q   <= bad_par_d;
            wd_q        <= wd_d;
            byte_done_q <= byte_done_d;
            byte_q      <= byte_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
        end
    end

    // Frame sequencing on each clock fall; watchdog aborts a stalled frame.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        bad_par_d   = bad_par_q;
        wd_d        = '0;
        byte_done_d = 1'b0;
        byte_d      = byte_q;
        err_par_d   = 1'b0;
        err_frm_d   = 1'b0;
        timeout     = 1'b0;

        if (state_q != IDLE && !fall) begin
            if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
                timeout = 1'b1;
            end else begin
                wd_d = wd_q + WW'(1);
            end
        end

        if (timeout) begin
            err_frm_d = 1'b1;
            state_d   = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_f) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        bad_par_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d   = {data_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    bad_par_d = !ps2_parity_ok(shift_q, data_f);
                    state_d   = STOP;
                end
                STOP: begin
                    if (bad_par_q) begin
                        err_par_d = 1'b1;
                    end else if (!data_f) begin
                        err_frm_d = 1'b1;
                    end else begin
                        byte_done_d = 1'b1;
                        byte_d      = shift_q;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic     ext_q, ext_d;
    logic     brk_q, brk_d;
    logic     push;
    ps2_evt_t push_evt;

    // Prefix flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

    // Fold E0/F0 prefixes into the next ordinary code; any frame error resets them.
    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        push          = 1'b0;
        push_evt.brk  = brk_q;
        push_evt.ext  = ext_q;
        push_evt.code = byte_q;
        if (err_par_q || err_frm_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_done_q) begin
            if (byte_q == PS2_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_PFX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    ps2_evt_t      mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] remain;
    ps2_evt_t      head_q, head_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          full;
    logic          wr_en;

    assign pop   = evt_valid && evt_ready;
    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    // FIFO pointers, level, registered head and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are qualified by the level so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_evt;
        end
    end

    // Next head: oldest surviving entry, else the entry being written into an empty FIFO.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        remain   = pop ? level_q - LW'(1) : level_q;
        level_d  = wr_en ? remain + LW'(1) : remain;
        ovf_d    = push && full && !pop;
        head_d   = head_q;
        if (remain != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (wr_en) begin
            head_d = push_evt;
        end
    end

    assign evt_valid  = (level_q != '0);
    assign evt_break  = head_q.brk;
    assign evt_ext    = head_q.ext;
    assign evt_code   = head_q.code;
    assign fifo_level = level_q;
    assign err_parity = err_par_q;
    assign err_frame  = err_frm_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb/tb_ps2_key_event_rx.sv - randomized self-checking bench with event-level reference model
module tb_ps2_key_event_rx;

    localparam int FL    = 4;
    localparam int TO    = 300;
    localparam int DEPTH = 8;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       evt_valid, evt_break, evt_ext;
    logic [7:0] evt_code;
    logic [$clog2(DEPTH):0] fifo_level;
    logic       err_parity, err_frame, overflow;

    int checks = 0;
    int errors = 0;
    int cnt_par = 0, cnt_frm = 0, cnt_ovf = 0;
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;
    int ready_mode = 0;

    logic [9:0] q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [9:0] last_evt = '0;

    always #5 clk = ~clk;

    ps2_key_event_rx #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_break  (evt_break),
        .evt_ext    (evt_ext),
        .evt_code   (evt_code),
        .fifo_level (fifo_level),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: prefix folding and a bounded queue of pending events.
    task automatic model_clear_flags();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (ready_mode == 0 && q.size() == DEPTH) exp_ovf++;
            else q.push_back({m_brk, m_ext, b});
            model_clear_flags();
        end
    endtask

    // Ready driver: 0 = hold off, 1 = always ready, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       evt_ready = 1'b0;
                1:       evt_ready = 1'b1;
                default: evt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare against the model queue and error pulse tallies.
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid_vs_level", {31'd0, evt_valid}, {31'd0, fifo_level != 0});
            if (err_parity) cnt_par++;
            if (err_frame)  cnt_frm++;
            if (overflow)   cnt_ovf++;
            if (evt_valid && evt_ready) begin
                check("evt_head", {21'd0, 1'b0, evt_break, evt_ext, evt_code},
                      (q.size() != 0) ? {21'd0, 1'b0, q[0]} : 32'h400);
                last_evt = {evt_break, evt_ext, evt_code};
                if (q.size() != 0) void'(q.pop_front());
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input bit measure);
        logic [10:0] bits;
        int lat;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = (~^b) ^ bad_par;
        bits[10]   = ~bad_stop;
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            wait_clk(HALF);
            if (i == 10) begin
                if (bad_par) begin
                    exp_par++;
                    model_clear_flags();
                end else if (bad_stop) begin
                    exp_frm++;
                    model_clear_flags();
                end else begin
                    model_byte(b);
                end
            end
            ps2_clk = 1'b0;
            if (measure && i == 10) begin
                lat = 0;
                for (int k = 1; k <= 20; k++) begin
                    @(posedge clk);
                    #1;
                    if (evt_valid && lat == 0) lat = k;
                end
                #1;
                check("valid_latency", lat, FL + 4);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b1;
            if (glitch_bit == i) begin
                wait_clk(3);
                ps2_clk = 1'b0;
                wait_clk(FL - 1);
                ps2_clk = 1'b1;
                wait_clk(HALF - 3 - (FL - 1));
            end else begin
                wait_clk(HALF);
            end
        end
        ps2_data = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Start bit plus n data bits, then the host stops clocking.
    task automatic send_partial(input int n);
        for (int i = 0; i <= n; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic settle(input string tag);
        wait_clk(30);
        check({tag, "_par"}, exp_par, cnt_par);
        check({tag, "_frm"}, exp_frm, cnt_frm);
        check({tag, "_ovf"}, exp_ovf, cnt_ovf);
        check({tag, "_level"}, {28'd0, fifo_level}, q.size());
    endtask

    initial begin
        logic [7:0] c;
        int r;
        wait_clk(3);
        check("rst_valid", {31'd0, evt_valid}, 0);
        check("rst_level", {28'd0, fifo_level}, 0);
        check("rst_errs", {29'd0, err_parity, err_frame, overflow}, 0);
        check("rst_head", {22'd0, evt_break, evt_ext, evt_code}, 0);
        rst_n = 1'b1;
        wait_clk(5);
        ready_mode = 1;
        wait_clk(3);

        send_frame(8'h1C, 0, 0, -1, 1);
        settle("make");
        check("make_lit", {22'd0, last_evt}, 32'h01C);

        send_frame(8'hF0, 0, 0, -1, 0);
        send_frame(8'h1C, 0, 0, -1, 0);
        settle("brk");
        check("brk_lit", {22'd0, last_evt}, 32'h21C);
        send_frame(8'hE0, 0, 0, -1, 0);
        send_frame(8'hF0, 0, 0, -1, 0);
        send_frame(8'h75, 0, 0, -1, 0);
        settle("extbrk");
        check("extbrk_lit", {22'd0, last_evt}, 32'h375);
        send_frame(8'h1C, 0, 0, -1, 0);
        check("plain_lit", {22'd0, last_evt}, 32'h01C);

        send_frame(8'h1C, 1, 0, -1, 0);
        settle("par");
        send_frame(8'hE0, 0, 0, -1, 0);
        send_frame(8'h1C, 1, 0, -1, 0);
        send_frame(8'h75, 0, 0, -1, 0);
        settle("par_clr");
        check("par_lit_cnt", cnt_par, 2);
        check("par_clr_lit", {22'd0, last_evt}, 32'h075);

        send_partial(4);
        exp_frm++;
        model_clear_flags();
        wait_clk(TO + 10);
        settle("tmo");
        check("tmo_lit_cnt", cnt_frm, 1);
        send_frame(8'h23, 0, 0, -1, 0);
        settle("tmo_after");
        check("tmo_after_lit", {22'd0, last_evt}, 32'h023);

        ready_mode = 0;
        wait_clk(5);
        for (int i = 0; i < DEPTH + 2; i++) send_frame(8'h10 + 8'(i), 0, 0, -1, 0);
        settle("full");
        check("full_lit_level", {28'd0, fifo_level}, DEPTH);
        check("full_lit_ovf", cnt_ovf, 2);
        ready_mode = 1;
        wait_clk(30);
        check("drain_empty", q.size(), 0);
        check("drain_last", {22'd0, last_evt}, 32'h017);
        check("hold_code", {24'd0, evt_code}, 32'h17);

        send_frame(8'h5A, 0, 0, 4, 0);
        settle("glitch");
        check("glitch_lit", {22'd0, last_evt}, 32'h05A);

        send_frame(8'hE0, 0, 0, -1, 0);
        send_partial(3);
        rst_n = 1'b0;
        q.delete();
        model_clear_flags();
        wait_clk(3);
        check("midrst_level", {28'd0, fifo_level}, 0);
        rst_n = 1'b1;
        wait_clk(5);
        send_frame(8'h2B, 0, 0, -1, 0);
        settle("midrst");
        check("midrst_lit", {22'd0, last_evt}, 32'h02B);

        ready_mode = 2;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) send_frame(8'hE0, 0, 0, -1, 0);
            r = $urandom_range(0, 9);
            if (r < 3) send_frame(8'hF0, 0, 0, -1, 0);
            do c = 8'($urandom_range(1, 254)); while (c == 8'hE0 || c == 8'hF0);
            r = $urandom_range(0, 9);
            send_frame(c, r == 0, r == 1, -1, 0);
        end
        ready_mode = 1;
        wait_clk(10);
        settle("rand");
        check("rand_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
